energy_trigger: RTL and testbench
=================================

// Module: energy_trigger
// PURPOSE
//  Packet-detect trigger for the CSI extractor front end, parametrised successor of the single-rail I trigger.
//  Computes L1 magnitude |I|+|Q| per sample and a moving average over 2^WIN_LOG2 samples.
//  Detects packets with on/off hysteresis thresholds, programmable at run time.
//  Emits a level, start/end pulses and measured packet length to the downstream CSI capture logic.
// PARAMETERS
//  SAMPLE_W    16  bits per I and Q component (two's complement)
//  WIN_LOG2    4   log2 of moving-average window depth (window N = 2^WIN_LOG2)
//  SKIP_SAMPLE 0   valid samples discarded after reset (not entered into window)
//  HOLD_LEN    80  consecutive evaluated samples with avg < thresh_off needed to end a packet (>=1)
// PORTS
//  clk_in             in  1           system clock
//  rst_in             in  1           synchronous, active-high reset
//  signal_data_in     in  2*SAMPLE_W  {I[2W-1:W], Q[W-1:0]}
//  signal_valid_in    in  1           sample qualifier, no backpressure
//  thresh_on_in       in  SAMPLE_W+1  avg >= this starts a packet
//  thresh_off_in      in  SAMPLE_W+1  avg < this counts toward packet end
//  trigger_out        out 1           high while in PACKET
//  trigger_start_out  out 1           1-cycle pulse on PACKET entry
//  trigger_end_out    out 1           1-cycle pulse on PACKET exit
//  power_out          out SAMPLE_W+1  current moving average
//  power_valid_out    out 1           power_out updated this cycle
//  pkt_len_out        out 16          length of last packet, latched with trigger_end_out
// BEHAVIOUR
//  Reset: all outputs 0; window history and sum cleared; state SKIP; counters 0. Reset mid-packet: no end pulse.
//  Arithmetic: |x| in SAMPLE_W bits unsigned (|-2^(W-1)| = 2^(W-1), no saturation); mag is SAMPLE_W+1 bits.
//    sum (SAMPLE_W+1+WIN_LOG2 bits) <= sum + mag_new - mag_oldest; never overflows.
//    avg = sum >> WIN_LOG2 (truncating).
//  Pipeline: fixed, no stalls, valid flags travel with data.
//    S1 registers mag; S2 registers sum/avg and drives power_out/power_valid_out; S3 registers state decision.
//    trigger_out/start/end change 3 clk after the causing signal_valid_in cycle.
//  FSM (advances only on evaluated samples = S2 valid):
//    SKIP: first SKIP_SAMPLE input valids dropped before S1; SKIP_SAMPLE=0 skips none. Then -> FILL.
//    FILL: first N evaluated samples fill window, no comparison; -> IDLE after Nth.
//    IDLE: avg >= thresh_on_in -> PACKET; trigger_out<=1; start pulse; len_cnt<=1; hold_cnt<=0.
//    PACKET: len_cnt +1 per evaluated sample, saturating at 16'hFFFF.
//      avg < thresh_off_in: hold_cnt+1. Else hold_cnt<=0.
//      hold_cnt reaching HOLD_LEN -> IDLE; trigger_out<=0; end pulse; pkt_len_out<=len_cnt (includes hold samples).
//  Thresholds are read combinationally at each evaluation; a change applies to the next evaluated sample.
//  thresh_off_in > thresh_on_in is legal; behaviour follows the rules above (no special case).
//  Start and end for the same sample are impossible: end only from PACKET after >= HOLD_LEN samples.
// CONFIGURATION
//  ENERGY_TRIG_STATS_EN defined: adds outputs pkt_count_out[15:0] and peak_power_out[SAMPLE_W:0].
//    pkt_count_out: packets started since reset, wraps at 2^16, increments with start pulse.
//    peak_power_out: max avg within current/last packet, reset to avg at start, updated in PACKET.
//  Undefined: these ports and their logic do not exist; all other behaviour identical.
// STRUCTURE
//  Package energy_trigger_pkg holds:
//    state_t enum {SKIP, FILL, IDLE, PACKET};
//    width helpers MAG_W = SAMPLE_W+1 and SUM_W = MAG_W+WIN_LOG2 as functions of parameters.
//  Sub-module moving_sum: depth-2^WIN_LOG2 circular history + running sum.
//    Ports: clk_in, rst_in, mag_in, valid_in, sum_out, valid_out. Resets history to 0.
// TESTING (SAMPLE_W=16, WIN_LOG2=2, HOLD_LEN=3, thresh_on=1000, thresh_off=500 unless noted)
//  1 SKIP_SAMPLE=5: 5 samples I=Q=4000, then 4 zero samples -> no trigger; power_out stays 0; FILL ends on 4th zero.
//  2 Rise, after FILL with zeros: stream I=600,Q=-600 (mag 1200).
//    -> power_out 300, 600, 900, 1200; start pulse and trigger_out=1 3 clk after 4th valid.
//  3 Hysteresis: in PACKET, mag 700 for 20 samples -> trigger stays 1.
//    Then mag 0: avg 525, 350, 175, 0 -> end pulse on 3rd sample below 500; pkt_len_out = total evaluated samples in packet.
//  4 Glitch: in PACKET, 2 samples avg<500 then avg>=500 -> hold_cnt clears, no end pulse.
//  5 Extremes: I=Q=-32768 for 4 samples -> power_out=65536, no wrap; I=Q=32767 -> 65534.
//  6 Reset mid-packet, with gaps in signal_valid_in -> all outputs 0 next cycle; no end pulse; SKIP/FILL repeated.
//    With ENERGY_TRIG_STATS_EN: pkt_count_out=0 after reset.

Source files
------------

// File: rtl/energy_trigger_pkg.sv
// Shared types and width helpers for the energy trigger datapath.
package energy_trigger_pkg;

  typedef enum logic [1:0] {
    SKIP   = 2'd0,
    FILL   = 2'd1,
    IDLE   = 2'd2,
    PACKET = 2'd3
  } state_t;

  function automatic int mag_w(input int sample_w);
    return sample_w + 1;
  endfunction

  function automatic int sum_w(input int sample_w, input int win_log2);
    return mag_w(sample_w) + win_log2;
  endfunction

endpackage

// File: rtl/energy_trigger_if.sv
// Sample/threshold inputs and trigger/power outputs of the energy trigger.
// ENERGY_TRIG_STATS_EN adds pkt_count_out and peak_power_out.
interface energy_trigger_if #(
  parameter int SAMPLE_W = 16
);
  logic [2*SAMPLE_W-1:0] signal_data_in;
  logic                  signal_valid_in;
  logic [SAMPLE_W:0]     thresh_on_in;
  logic [SAMPLE_W:0]     thresh_off_in;
  logic                  trigger_out;
  logic                  trigger_start_out;
  logic                  trigger_end_out;
  logic [SAMPLE_W:0]     power_out;
  logic                  power_valid_out;
  logic [15:0]           pkt_len_out;
`ifdef ENERGY_TRIG_STATS_EN
  logic [15:0]           pkt_count_out;
  logic [SAMPLE_W:0]     peak_power_out;
`endif

  modport master (
    output signal_data_in, signal_valid_in, thresh_on_in, thresh_off_in,
    input  trigger_out, trigger_start_out, trigger_end_out,
    input  power_out, power_valid_out, pkt_len_out
`ifdef ENERGY_TRIG_STATS_EN
    , input pkt_count_out, peak_power_out
`endif
  );

  modport slave (
    input  signal_data_in, signal_valid_in, thresh_on_in, thresh_off_in,
    output trigger_out, trigger_start_out, trigger_end_out,
    output power_out, power_valid_out, pkt_len_out
`ifdef ENERGY_TRIG_STATS_EN
    , output pkt_count_out, peak_power_out
`endif
  );
endinterface

// File: rtl/energy_trigger_moving_sum.sv
// Running sum over the last 2^WIN_LOG2 magnitudes using a circular history.
module moving_sum
  import energy_trigger_pkg::*;
#(
  parameter  int SAMPLE_W = 16,
  parameter  int WIN_LOG2 = 4,
  localparam int MAG_W    = mag_w(SAMPLE_W),
  localparam int SUM_W    = sum_w(SAMPLE_W, WIN_LOG2)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [MAG_W-1:0] mag_in,
  input  logic             valid_in,
  output logic [SUM_W-1:0] sum_out,
  output logic             valid_out
);
  localparam int DEPTH = 1 << WIN_LOG2;

  logic [MAG_W-1:0]    hist_q [DEPTH];
  logic [WIN_LOG2-1:0] ptr_q;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                valid_q;

  // The oldest entry is always part of sum_q, so the subtraction cannot underflow.
  assign sum_d = sum_q + SUM_W'(mag_in) - SUM_W'(hist_q[ptr_q]);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < DEPTH; k++) hist_q[k] <= '0;
      ptr_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        sum_q         <= sum_d;
        hist_q[ptr_q] <= mag_in;
        ptr_q         <= ptr_q + WIN_LOG2'(1);
      end
    end
  end

  assign sum_out   = sum_q;
  assign valid_out = valid_q;
endmodule

// File: rtl/energy_trigger.sv
// Packet-detect trigger: L1 magnitude, moving average, hysteresis FSM.
// Define ENERGY_TRIG_STATS_EN for packet count and peak power outputs.
module energy_trigger
  import energy_trigger_pkg::*;
#(
  parameter int SAMPLE_W    = 16,
  parameter int WIN_LOG2    = 4,
  parameter int SKIP_SAMPLE = 0,
  parameter int HOLD_LEN    = 80
) (
  input logic             clk_in,
  input logic             rst_in,
  energy_trigger_if.slave bus
);
  // state  | meaning
  // SKIP   | dropping the first SKIP_SAMPLE input valids after reset
  // FILL   | first 2^WIN_LOG2 evaluated samples fill the window, no compare
  // IDLE   | waiting for avg >= thresh_on
  // PACKET | trigger high, counting length and below-off hold samples
  localparam int MAG_W  = mag_w(SAMPLE_W);
  localparam int SUM_W  = sum_w(SAMPLE_W, WIN_LOG2);
  localparam int SKIP_W = $clog2(SKIP_SAMPLE + 2);
  localparam int HOLD_W = $clog2(HOLD_LEN + 1);
  localparam int FILL_W = WIN_LOG2 + 1;
  localparam logic [SKIP_W-1:0] SKIP_LIM = SKIP_W'(SKIP_SAMPLE);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_LEN);
  localparam logic [FILL_W-1:0] FILL_LIM = FILL_W'(1 << WIN_LOG2);

  logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
  logic                skip_active;
  logic [SAMPLE_W-1:0] samp_i, samp_q, abs_i, abs_q;
  logic [MAG_W-1:0]    mag_q, mag_d;
  logic                mag_valid_q, mag_valid_d;
  logic [SUM_W-1:0]    sum_s2;
  logic                eval;
  logic [MAG_W-1:0]    avg;

  state_t              state_q, state_d;
  logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d, hold_inc;
  logic [15:0]         len_cnt_q, len_cnt_d, len_inc;
  logic [15:0]         pkt_len_q, pkt_len_d;
  logic                trigger_q, trigger_d, start_q, start_d, end_q, end_d;

  assign skip_active = skip_cnt_q < SKIP_LIM;
  assign skip_cnt_d  = (bus.signal_valid_in && skip_active) ? skip_cnt_q + SKIP_W'(1) : skip_cnt_q;
  assign samp_i      = bus.signal_data_in[2*SAMPLE_W-1:SAMPLE_W];
  assign samp_q      = bus.signal_data_in[SAMPLE_W-1:0];
  // -2^(W-1) negates to itself, which reads correctly as unsigned 2^(W-1).
  assign abs_i       = samp_i[SAMPLE_W-1] ? (~samp_i) + SAMPLE_W'(1) : samp_i;
  assign abs_q       = samp_q[SAMPLE_W-1] ? (~samp_q) + SAMPLE_W'(1) : samp_q;
  assign mag_d       = MAG_W'(abs_i) + MAG_W'(abs_q);
  assign mag_valid_d = bus.signal_valid_in && !skip_active;

  moving_sum #(.SAMPLE_W(SAMPLE_W), .WIN_LOG2(WIN_LOG2)) u_moving_sum (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .mag_in   (mag_q),
    .valid_in (mag_valid_q),
    .sum_out  (sum_s2),
    .valid_out(eval)
  );

  assign avg = MAG_W'(sum_s2 >> WIN_LOG2);

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    hold_cnt_d = hold_cnt_q;
    len_cnt_d  = len_cnt_q;
    hold_inc   = hold_cnt_q + HOLD_W'(1);
    len_inc    = (len_cnt_q == 16'hFFFF) ? len_cnt_q : len_cnt_q + 16'd1;
    unique case (state_q)
      SKIP: if (!skip_active) state_d = FILL;
      FILL: if (eval) begin
        fill_cnt_d = fill_cnt_q + FILL_W'(1);
        if (fill_cnt_d == FILL_LIM) state_d = IDLE;
      end
      IDLE: if (eval && avg >= bus.thresh_on_in) begin
        state_d    = PACKET;
        len_cnt_d  = 16'd1;
        hold_cnt_d = '0;
      end
      PACKET: if (eval) begin
        len_cnt_d = len_inc;
        if (avg < bus.thresh_off_in) begin
          hold_cnt_d = hold_inc;
          if (hold_inc == HOLD_LIM) state_d = IDLE;
        end else begin
          hold_cnt_d = '0;
        end
      end
      default: state_d = SKIP;
    endcase
  end

  always_comb begin
    start_d   = (state_q == IDLE) && (state_d == PACKET);
    end_d     = (state_q == PACKET) && (state_d == IDLE);
    trigger_d = (state_d == PACKET);
    pkt_len_d = end_d ? len_inc : pkt_len_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      skip_cnt_q  <= '0;
      mag_q       <= '0;
      mag_valid_q <= 1'b0;
      state_q     <= SKIP;
      fill_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      len_cnt_q   <= '0;
      pkt_len_q   <= '0;
      trigger_q   <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      skip_cnt_q  <= skip_cnt_d;
      mag_q       <= mag_d;
      mag_valid_q <= mag_valid_d;
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      len_cnt_q   <= len_cnt_d;
      pkt_len_q   <= pkt_len_d;
      trigger_q   <= trigger_d;
      start_q     <= start_d;
      end_q       <= end_d;
    end
  end

  assign bus.trigger_out       = trigger_q;
  assign bus.trigger_start_out = start_q;
  assign bus.trigger_end_out   = end_q;
  assign bus.power_out         = avg;
  assign bus.power_valid_out   = eval;
  assign bus.pkt_len_out       = pkt_len_q;

`ifdef ENERGY_TRIG_STATS_EN
  logic [15:0]      pkt_count_q, pkt_count_d;
  logic [MAG_W-1:0] peak_q, peak_d;

  always_comb begin
    pkt_count_d = start_d ? pkt_count_q + 16'd1 : pkt_count_q;
    peak_d      = peak_q;
    if (start_d) peak_d = avg;
    else if (state_q == PACKET && eval && avg > peak_q) peak_d = avg;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pkt_count_q <= '0;
      peak_q      <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
      peak_q      <= peak_d;
    end
  end

  assign bus.pkt_count_out  = pkt_count_q;
  assign bus.peak_power_out = peak_q;
`endif
endmodule

// File: tb/tb_energy_trigger.sv
// Self-checking bench for energy_trigger: directed sequences, a steady-level
// vector table and randomized traffic against a window-average reference model.
module tb_energy_trigger;
  localparam int SW = 16, WL = 2, N = 4, SKIP_N = 5, HOLD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  energy_trigger_if #(.SAMPLE_W(SW)) bus ();

  energy_trigger #(.SAMPLE_W(SW), .WIN_LOG2(WL), .SKIP_SAMPLE(SKIP_N), .HOLD_LEN(HOLD)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  typedef struct {
    int pwr; int pv; int trig; int st; int en; int len; int cnt; int peak;
  } rec_t;

  typedef struct { int i; int q; int exp_pwr; } vec_t;

  int   n_cmp = 0, n_err = 0;
  rec_t hist[3];
  int   win[$];
  int   m_skipped, m_fill, m_in_pkt, m_below, m_len, m_pkt_len, m_pwr, m_cnt, m_peak;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int absv(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    m_skipped = 0; m_fill = 0; m_in_pkt = 0; m_below = 0; m_len = 0;
    m_pkt_len = 0; m_pwr = 0; m_cnt = 0; m_peak = 0;
    win = {0, 0, 0, 0};
    for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0, 0, 0, 0, 0};
  endtask

  task automatic model_step(input bit v, input int i, input int q, output rec_t r);
    int s, avg;
    r = '{m_pwr, 0, 0, 0, 0, 0, 0, 0};
    if (v) begin
      if (m_skipped < SKIP_N) m_skipped++;
      else begin
        win.push_back(absv(i) + absv(q));
        void'(win.pop_front());
        s = 0;
        foreach (win[k]) s += win[k];
        avg = s / N;
        m_pwr = avg; r.pwr = avg; r.pv = 1;
        if (m_fill < N) m_fill++;
        else if (!m_in_pkt) begin
          if (avg >= int'(bus.thresh_on_in)) begin
            m_in_pkt = 1; r.st = 1; m_len = 1; m_below = 0;
            m_cnt = (m_cnt + 1) % 65536; m_peak = avg;
          end
        end else begin
          m_len = (m_len < 65535) ? m_len + 1 : 65535;
          if (avg > m_peak) m_peak = avg;
          if (avg < int'(bus.thresh_off_in)) m_below++;
          else m_below = 0;
          if (m_below == HOLD) begin
            m_in_pkt = 0; r.en = 1; m_pkt_len = m_len;
          end
        end
      end
    end
    r.trig = m_in_pkt; r.len = m_pkt_len; r.cnt = m_cnt; r.peak = m_peak;
  endtask

  // Called at a negedge; returns at the next negedge after checking every output.
  task automatic drive(input bit v, input int i, input int q);
    rec_t r;
    bus.signal_valid_in = v;
    bus.signal_data_in  = {16'(i), 16'(q)};
    model_step(v, i, q, r);
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = r;
    @(posedge clk); #1;
    chk("power", int'(bus.power_out), hist[1].pwr);
    chk("power_valid", int'(bus.power_valid_out), hist[1].pv);
    chk("trigger", int'(bus.trigger_out), hist[2].trig);
    chk("start", int'(bus.trigger_start_out), hist[2].st);
    chk("end", int'(bus.trigger_end_out), hist[2].en);
    chk("pkt_len", int'(bus.pkt_len_out), hist[2].len);
`ifdef ENERGY_TRIG_STATS_EN
    chk("pkt_count", int'(bus.pkt_count_out), hist[2].cnt);
    chk("peak_power", int'(bus.peak_power_out), hist[2].peak);
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.signal_valid_in = 1'b0;
    @(posedge clk); #1;
    chk("rst_trigger", int'(bus.trigger_out), 0);
    chk("rst_start", int'(bus.trigger_start_out), 0);
    chk("rst_end", int'(bus.trigger_end_out), 0);
    chk("rst_power", int'(bus.power_out), 0);
    chk("rst_power_valid", int'(bus.power_valid_out), 0);
    chk("rst_pkt_len", int'(bus.pkt_len_out), 0);
`ifdef ENERGY_TRIG_STATS_EN
    chk("rst_pkt_count", int'(bus.pkt_count_out), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic skip_and_fill();
    for (int k = 0; k < SKIP_N; k++) begin
      drive(1, 4000, 4000);
      chk("skip_power", int'(bus.power_out), 0);
    end
    for (int k = 0; k < N; k++) begin
      drive(1, 0, 0);
      chk("fill_trigger", int'(bus.trigger_out), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   exp_rise[4];
    int   lvl, si, sq;
    bit   v;

    tbl[0] = '{-32768, -32768, 65536};
    tbl[1] = '{ 32767,  32767, 65534};
    tbl[2] = '{   600,   -600,  1200};
    tbl[3] = '{    -1,      1,     2};
    tbl[4] = '{     0, -32768, 32768};
    tbl[5] = '{     0,      0,     0};
    tbl[6] = '{  -700,      0,   700};
    tbl[7] = '{  1000,   -999,  1999};
    exp_rise = '{300, 600, 900, 1200};

    bus.signal_valid_in = 1'b0;
    bus.signal_data_in  = '0;
    bus.thresh_on_in    = 17'd1000;
    bus.thresh_off_in   = 17'd500;
    model_reset();
    @(negedge clk);
    do_reset();

    // Skip five loud samples, then fill with zeros: no trigger, power 0.
    skip_and_fill();

    // Rise to mag 1200; start lands two drives after the 4th sample.
    for (int j = 0; j < 4; j++) begin
      drive(1, 600, -600);
      if (j > 0) chk("rise_power", int'(bus.power_out), exp_rise[j-1]);
    end
    drive(0, 0, 0);
    chk("rise_power", int'(bus.power_out), 1200);
    chk("rise_trigger_early", int'(bus.trigger_out), 0);
    drive(0, 0, 0);
    chk("rise_trigger", int'(bus.trigger_out), 1);
    chk("rise_start", int'(bus.trigger_start_out), 1);

    // Hysteresis: mag 700 holds the packet; zeros end it on the 3rd avg below 500.
    for (int k = 0; k < 20; k++) drive(1, 700, 0);
    chk("hyst_trigger", int'(bus.trigger_out), 1);
    for (int k = 0; k < 4; k++) drive(1, 0, 0);
    drive(0, 0, 0);
    chk("hyst_end_early", int'(bus.trigger_end_out), 0);
    drive(0, 0, 0);
    chk("hyst_end", int'(bus.trigger_end_out), 1);
    chk("hyst_trigger_off", int'(bus.trigger_out), 0);
    chk("hyst_pkt_len", int'(bus.pkt_len_out), 25);

    // Glitch: two averages below off, then one above, must not end the packet.
    for (int k = 0; k < 4; k++) drive(1, 1200, 0);
    for (int k = 0; k < 4; k++) drive(1, 0, 0);
    drive(1, 2400, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("glitch_trigger", int'(bus.trigger_out), 1);
    chk("glitch_no_end", int'(bus.trigger_end_out), 0);
    for (int k = 0; k < 6; k++) drive(1, 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("glitch_end", int'(bus.trigger_end_out), 1);
    chk("glitch_pkt_len", int'(bus.pkt_len_out), 12);

    // Steady-level table, including the magnitude extremes.
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < N; k++) drive(1, tbl[t].i, tbl[t].q);
      drive(0, 0, 0);
      drive(0, 0, 0);
      chk("table_power", int'(bus.power_out), tbl[t].exp_pwr);
    end

    // Reset in the middle of a gappy packet, then SKIP/FILL must repeat.
    for (int k = 0; k < 8; k++) begin
      drive(1, 2000, 0);
      if ($urandom_range(0, 1) == 1) drive(0, 0, 0);
    end
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("pre_reset_trigger", int'(bus.trigger_out), 1);
    do_reset();
    skip_and_fill();

    // Randomized bursts around the thresholds.
    lvl = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 600 == 599) begin
        for (int k = 0; k < 3; k++) drive(0, 0, 0);
        bus.thresh_on_in  = 17'($urandom_range(200, 2500));
        bus.thresh_off_in = 17'($urandom_range(100, 2500));
      end
      if (n % 1100 == 1099) do_reset();
      if (n % 16 == 0)
        lvl = ($urandom_range(0, 15) == 0) ? 32768 : int'($urandom_range(0, 2400));
      v  = ($urandom_range(0, 3) != 0);
      si = lvl / 2 + int'($urandom_range(0, 100)) - 50;
      sq = lvl / 2 + int'($urandom_range(0, 100)) - 50;
      if (si > 32767) si = 32767;
      if (sq > 32767) sq = 32767;
      if ($urandom_range(0, 1) == 1) si = -si;
      if ($urandom_range(0, 1) == 1) sq = -sq;
      drive(v, si, sq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
